// File: rtl/report_reader.sv
// Periodically reads a fixed 64-bit report buffer over a simple memory port and
// presents each changed report to a consumer through a valid/ready handshake.
module report_reader #(
  parameter int unsigned POLL_COUNT   = 200000,
  parameter int unsigned RESP_TIMEOUT = 1024,
  parameter logic [31:0] RD_ADDR      = 32'h0005_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        bmem_rd_en,
  output logic [31:0] bmem_rd_addr,
  input  logic        bmem_resp,
  input  logic [63:0] bmem_rd_data,
  output logic [63:0] report_o,
  output logic        report_valid,
  input  logic        report_ready,
  output logic        timeout_err
);

  localparam int unsigned POLL_W = 18;
  localparam int unsigned WAIT_W = 10;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned ADDR_W = 32;

  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_COUNT - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RESP_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    CHECK = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [POLL_W-1:0]   poll_cnt_q, poll_cnt_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [DATA_W-1:0]   rd_buf_q, rd_buf_d;
  logic [DATA_W-1:0]   last_report_q, last_report_d;
  logic                seen_q, seen_d;
  logic                rd_en_d;
  logic [ADDR_W-1:0]   rd_addr_d;
  logic                valid_d;
  logic                timeout_d;
  logic                poll_tick;

  // Free-running poll timebase; runs regardless of FSM state so ticks seen
  // outside IDLE are simply lost.
  assign poll_tick  = (poll_cnt_q == POLL_LAST);
  assign poll_cnt_d = poll_tick ? '0 : poll_cnt_q + POLL_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      poll_cnt_q    <= '0;
      wait_cnt_q    <= '0;
      rd_buf_q      <= '0;
      last_report_q <= '0;
      seen_q        <= 1'b0;
      bmem_rd_en    <= 1'b0;
      bmem_rd_addr  <= '0;
      report_valid  <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      state_q       <= state_d;
      poll_cnt_q    <= poll_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      rd_buf_q      <= rd_buf_d;
      last_report_q <= last_report_d;
      seen_q        <= seen_d;
      bmem_rd_en    <= rd_en_d;
      bmem_rd_addr  <= rd_addr_d;
      report_valid  <= valid_d;
      timeout_err   <= timeout_d;
    end
  end

  // Next-state logic; outputs are decoded from the next state so the
  // registered copies line up exactly with the state they describe.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    rd_buf_d      = rd_buf_q;
    last_report_d = last_report_q;
    seen_d        = seen_q;
    timeout_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (poll_tick) begin
          state_d    = READ;
          wait_cnt_d = '0;
        end
      end
      READ: begin
        // A response arriving in the final wait cycle still wins.
        if (bmem_resp) begin
          rd_buf_d = bmem_rd_data;
          state_d  = CHECK;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      CHECK: begin
        if (!seen_q || (rd_buf_q != last_report_q)) begin
          last_report_d = rd_buf_q;
          seen_d        = 1'b1;
          state_d       = HOLD;
        end else begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (report_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    rd_en_d   = (state_d == READ);
    rd_addr_d = rd_en_d ? RD_ADDR : '0;
    valid_d   = (state_d == HOLD);
  end

  assign report_o = last_report_q;

endmodule

// File: tb/tb_report_reader.sv
// Directed bench for report_reader: expected reports are queued when the read
// response is driven and popped when report_valid is observed.
module tb_report_reader;

  localparam int unsigned POLL_COUNT   = 8;
  localparam int unsigned RESP_TIMEOUT = 4;
  localparam logic [31:0] RD_ADDR      = 32'h0005_0000;
  localparam logic [63:0] PATTERN      = 64'h0123_4567_89AB_CDEF;

  logic        clk;
  logic        rst;
  logic        bmem_rd_en;
  logic [31:0] bmem_rd_addr;
  logic        bmem_resp;
  logic [63:0] bmem_rd_data;
  logic [63:0] report_o;
  logic        report_valid;
  logic        report_ready;
  logic        timeout_err;

  int          checks;
  int          failures;
  int          cyc;
  logic [63:0] exp_q[$];
  logic [63:0] held;

  report_reader #(
    .POLL_COUNT  (POLL_COUNT),
    .RESP_TIMEOUT(RESP_TIMEOUT),
    .RD_ADDR     (RD_ADDR)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bmem_rd_en  (bmem_rd_en),
    .bmem_rd_addr(bmem_rd_addr),
    .bmem_resp   (bmem_resp),
    .bmem_rd_data(bmem_rd_data),
    .report_o    (report_o),
    .report_valid(report_valid),
    .report_ready(report_ready),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d: observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // Pops the oldest expected report and compares it with report_o.
  task automatic check_report(input string tag);
    logic [63:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s cyc=%0d: observed report %h but no report expected", tag, cyc, report_o);
    end else begin
      e = exp_q.pop_front();
      check(tag, report_o, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic step_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic check_idle_outs(input string tag);
    check({tag, "_rd_en"}, 64'(bmem_rd_en), 64'd0);
    check({tag, "_addr"}, 64'(bmem_rd_addr), 64'd0);
    check({tag, "_valid"}, 64'(report_valid), 64'd0);
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    cyc          = 0;
    rst          = 1'b1;
    bmem_resp    = 1'b0;
    bmem_rd_data = '0;
    report_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;

    // Reset state
    check_idle_outs("rst");
    check("rst_report_o", report_o, 64'd0);
    check("rst_timeout", 64'(timeout_err), 64'd0);

    // First poll: tick at cycle 7, read at 8, response at 10
    step_to(7);
    check("poll_pre_rd_en", 64'(bmem_rd_en), 64'd0);
    step_to(8);
    check("poll_rd_en", 64'(bmem_rd_en), 64'd1);
    check("poll_addr", 64'(bmem_rd_addr), 64'(RD_ADDR));
    step_to(10);
    check("poll_rd_en_hold", 64'(bmem_rd_en), 64'd1);
    bmem_resp    = 1'b1;
    bmem_rd_data = PATTERN;
    exp_q.push_back(PATTERN);
    step();
    bmem_resp    = 1'b0;
    bmem_rd_data = '0;
    check("check_rd_en", 64'(bmem_rd_en), 64'd0);
    check("check_valid", 64'(report_valid), 64'd0);
    step();
    check("first_valid", 64'(report_valid), 64'd1);
    held = report_o;
    check_report("first_report");

    // Backpressure: 30 cycles without ready, ticks at 15/23/31/39 dropped
    for (int i = 0; i < 30; i++) begin
      check("bp_valid", 64'(report_valid), 64'd1);
      check("bp_report", report_o, held);
      check("bp_rd_en", 64'(bmem_rd_en), 64'd0);
      step();
    end
    report_ready = 1'b1;
    step();
    report_ready = 1'b0;
    check("ack_valid", 64'(report_valid), 64'd0);
    step_to(44);
    check("no_queued_tick", 64'(bmem_rd_en), 64'd0);

    // Unchanged data: read at 48 with the same value
    step_to(47);
    check("unch_pre_rd_en", 64'(bmem_rd_en), 64'd0);
    step();
    check("unch_rd_en", 64'(bmem_rd_en), 64'd1);
    bmem_resp    = 1'b1;
    bmem_rd_data = PATTERN;
    step();
    bmem_resp    = 1'b0;
    bmem_rd_data = '0;
    step();
    check_idle_outs("unch");
    step();
    check("unch_valid_late", 64'(report_valid), 64'd0);

    // Timeout: read cycles 56..59, error pulse at 60
    step_to(56);
    for (int i = 0; i < 4; i++) begin
      check("to_rd_en", 64'(bmem_rd_en), 64'd1);
      check("to_early_err", 64'(timeout_err), 64'd0);
      step();
    end
    check("to_err", 64'(timeout_err), 64'd1);
    check_idle_outs("to");
    step();
    check("to_err_single", 64'(timeout_err), 64'd0);

    // Response in the timeout cycle (cycle 67) wins
    step_to(67);
    check("sim_rd_en", 64'(bmem_rd_en), 64'd1);
    bmem_resp    = 1'b1;
    bmem_rd_data = 64'h1;
    exp_q.push_back(64'h1);
    step();
    bmem_resp    = 1'b0;
    bmem_rd_data = '0;
    check("sim_no_err", 64'(timeout_err), 64'd0);
    check("sim_rd_en_off", 64'(bmem_rd_en), 64'd0);
    step();
    check("sim_no_err2", 64'(timeout_err), 64'd0);
    check("sim_valid", 64'(report_valid), 64'd1);
    check_report("sim_report");
    report_ready = 1'b1;
    step();
    report_ready = 1'b0;
    check("sim_ack_valid", 64'(report_valid), 64'd0);

    // Reset during READ (read starts at 72), late response ignored
    step_to(73);
    check("rr_rd_en", 64'(bmem_rd_en), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle_outs("rr");
    check("rr_report_o", report_o, 64'd0);
    bmem_resp    = 1'b1;
    bmem_rd_data = 64'h1;
    step();
    bmem_resp    = 1'b0;
    bmem_rd_data = '0;
    check("rr_no_err", 64'(timeout_err), 64'd0);
    check("rr_valid", 64'(report_valid), 64'd0);
    step();
    check("rr_valid2", 64'(report_valid), 64'd0);

    // Counter restarted at 74: read at 82, identical value reported again
    step_to(82);
    check("rr2_rd_en", 64'(bmem_rd_en), 64'd1);
    bmem_resp    = 1'b1;
    bmem_rd_data = 64'h1;
    exp_q.push_back(64'h1);
    step();
    bmem_resp    = 1'b0;
    bmem_rd_data = '0;
    step();
    check("rr2_valid", 64'(report_valid), 64'd1);
    check_report("rr2_report");

    // Reset during HOLD, then an all-zero read must still be reported
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle_outs("rh");
    check("rh_report_o", report_o, 64'd0);
    check("rh_no_err", 64'(timeout_err), 64'd0);
    step_to(93);
    check("zero_rd_en", 64'(bmem_rd_en), 64'd1);
    bmem_resp    = 1'b1;
    bmem_rd_data = 64'h0;
    exp_q.push_back(64'h0);
    step();
    bmem_resp = 1'b0;
    step();
    check("zero_valid", 64'(report_valid), 64'd1);
    check_report("zero_report");
    report_ready = 1'b1;
    step();
    report_ready = 1'b0;
    check("zero_ack_valid", 64'(report_valid), 64'd0);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/report_reader.md
REPORT_READER -- requirements
Module: report_reader

Interface
REQ-001 The module SHALL expose parameter POLL_COUNT, default 200000: poll period in clk cycles, range 2..262143.
REQ-002 The module SHALL expose parameter RESP_TIMEOUT, default 1024: maximum cycles to wait for bmem_resp, range 2..1024.
REQ-003 The module SHALL expose parameter RD_ADDR, default 32'h00050000: fixed report buffer address.
REQ-004 The design SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  sole clock, all state on posedge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 bmem_rd_en  output  1  read request, held high for the whole request.
REQ-008 bmem_rd_addr  output  32  read address; RD_ADDR when bmem_rd_en=1, else 32'h0.
REQ-009 bmem_resp  input  1  one-cycle read completion strobe.
REQ-010 bmem_rd_data  input  64  read data, valid only in the bmem_resp cycle.
REQ-011 report_o  output  64  last new report, stable while report_valid=1.
REQ-012 report_valid  output  1  report_o holds an unconsumed new report.
REQ-013 report_ready  input  1  consumer accepts report_o.
REQ-014 timeout_err  output  1  one-cycle pulse when a read is abandoned.

Function
REQ-015 The poll counter SHALL be 18 bits, free-running from 0 to POLL_COUNT-1 and then wrapping to 0; poll_tick SHALL be high in the cycle where the counter equals POLL_COUNT-1.
REQ-016 The FSM SHALL have the states IDLE, READ, CHECK and HOLD, and SHALL be in IDLE after reset.
REQ-017 IDLE->READ SHALL occur on the edge where poll_tick=1; bmem_rd_en SHALL go high in the next cycle.
REQ-018 A poll_tick in READ, CHECK or HOLD SHALL be dropped without queuing; the poll counter SHALL keep running.
REQ-019 In READ, bmem_rd_en SHALL be 1 and bmem_rd_addr SHALL equal RD_ADDR; in every other state both SHALL be 0 (no X).
REQ-020 In READ, bmem_resp=1 SHALL capture bmem_rd_data into rd_buf and cause the transition READ->CHECK.
REQ-021 A wait counter of 10 bits SHALL be cleared on entry to READ and SHALL increment each READ cycle without bmem_resp.
REQ-022 If the wait counter reaches RESP_TIMEOUT-1 with no bmem_resp, the FSM SHALL go READ->IDLE, SHALL pulse timeout_err for exactly 1 cycle, and SHALL not capture data.
REQ-023 bmem_resp in the same cycle as the timeout condition SHALL win: data is captured, the FSM goes to CHECK, and no timeout_err is raised.
REQ-024 bmem_resp SHALL be ignored in IDLE, CHECK and HOLD.
REQ-025 In CHECK, if seen=0 or rd_buf != last_report, then last_report SHALL be set to rd_buf, seen SHALL be set to 1, and the FSM SHALL go to HOLD; otherwise it SHALL go to IDLE.
REQ-026 report_o SHALL always equal last_report; report_valid SHALL be 1 exactly in HOLD.
REQ-027 In HOLD, report_ready=1 SHALL cause HOLD->IDLE; report_valid SHALL be low in the next cycle.
REQ-028 report_ready outside HOLD SHALL have no effect; HOLD SHALL have no timeout.
REQ-029 Latency from the bmem_resp cycle M SHALL be: CHECK at M+1 and report_valid=1 at M+2.
REQ-030 The comparison SHALL cover all 64 bits; an all-zero read SHALL be reported when seen=0.

Reset
REQ-031 While rst=1 at a posedge, the block SHALL set state=IDLE, poll counter=0, wait counter=0, rd_buf=0, last_report=0 and seen=0.
REQ-032 From the cycle after reset, the block SHALL drive bmem_rd_en=0, bmem_rd_addr=0, report_valid=0, report_o=0 and timeout_err=0.
REQ-033 rst asserted mid-READ or mid-HOLD SHALL abort the operation with no report and no timeout_err; a later bmem_resp SHALL be ignored.

Verification
REQ-034 The bench SHALL check a first poll with POLL_COUNT=8: rd_en rises at cycle 8, then bmem_resp with 64'h0123_4567_89AB_CDEF two cycles later -> report_valid=1 two cycles after resp, report_o=64'h0123_4567_89AB_CDEF.
REQ-035 The bench SHALL check an unchanged data poll: the same 64'h0123_4567_89AB_CDEF returned on the next poll -> no report_valid, and the FSM returns to IDLE after CHECK.
REQ-036 The bench SHALL check a timeout with RESP_TIMEOUT=4: no bmem_resp -> rd_en high for 4 cycles, then a single timeout_err pulse, with report_valid=0.
REQ-037 The bench SHALL check backpressure: report_ready held low for 30 cycles with POLL_COUNT=8 -> report_valid stays 1, report_o stays stable, rd_en stays 0 for the whole period, and ticks are dropped.
REQ-038 The bench SHALL check the simultaneous event: bmem_resp in the exact timeout cycle with data 64'h1 -> no timeout_err, and report_o=64'h1.
REQ-039 The bench SHALL check reset during READ: rst pulsed, then bmem_resp is returned -> rd_en=0 the cycle after rst, no report, and seen=0, so the next identical read is reported.
